// File: rtl/key_press_debouncer.sv
// Active-low pushbutton conditioner: per-key sync + debounce, then one-hot press arbitration.
// Optional auto-repeat of the winning key is built when KEY_AUTOREPEAT_EN is defined.
module key_lane #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic held,
  output logic held_next,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          state;  // debounced level, 1 = released
  logic [CW-1:0] cnt;
  logic          differ, terminal;

  assign differ    = sync[1] != state;
  assign terminal  = differ && (cnt == TERM);
  assign held      = ~state;
  assign held_next = terminal ? state : ~state;
  assign press     = terminal && state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync  <= 2'b11;
      state <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], key_raw};
      if (terminal) begin
        state <= ~state;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module key_press_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] posedge_key,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_held
);
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_press_debouncer: DEBOUNCE_CYCLES must be >= 2, repeat timings >= 1");
  end

  logic [NUM_KEYS-1:0] held_now, held_next, press, press_win, pulse;
  logic                found;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clock     (clock),
      .reset     (reset),
      .key_raw   (key[i]),
      .held      (held_now[i]),
      .held_next (held_next[i]),
      .press     (press[i])
    );
  end

  // A press only counts when nothing is already held; ties go to the lowest index.
  always_comb begin
    press_win = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (press[i] && !found && held_now == '0) begin
        press_win[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_T = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_T = RW'(REPEAT_PERIOD - 1);

  logic                rep_act, rep_first, rep_keep, rep_fire;
  logic [RW-1:0]       rep_cnt;
  logic [NUM_KEYS-1:0] rep_owner;

  // Repeating continues only while the owner alone stays held after this edge.
  assign rep_keep = rep_act && ((held_next & rep_owner) != '0) && ((held_next & ~rep_owner) == '0);
  assign rep_fire = rep_keep && (rep_cnt == (rep_first ? RD_T : RP_T));
  assign pulse    = press_win | (rep_fire ? rep_owner : '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
      rep_owner <= '0;
    end else if (press_win != '0) begin
      rep_act   <= 1'b1;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
      rep_owner <= press_win;
    end else if (!rep_keep) begin
      rep_act <= 1'b0;
      rep_cnt <= '0;
    end else if (rep_fire) begin
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign pulse = press_win;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      posedge_key <= '0;
      key_held    <= '0;
      any_held    <= 1'b0;
    end else begin
      posedge_key <= pulse;
      key_held    <= held_next;
      any_held    <= |held_next;
    end
  end
endmodule

// File: tb/tb_key_press_debouncer.sv
// Scoreboard bench: a window-based reference model queues expected outputs each edge,
// a negedge monitor pops and compares; directed scenarios plus random key traffic.
module tb_key_press_debouncer;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] key   = '1;
  logic [NK-1:0] posedge_key, key_held;
  logic          any_held;

  key_press_debouncer #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .key(key),
    .posedge_key(posedge_key), .key_held(key_held), .any_held(any_held)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NK-1:0] pulse;
    logic [NK-1:0] held;
    logic          any;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   pulse_cnt [NK];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a key's debounced level flips once its raw input, seen two edges
  // late, has disagreed with that level for DB consecutive edges.
  bit [NK-1:0] m_rel;
  bit          hist [NK][DB+1];
  bit [NK-1:0] m_new, m_press, m_pulse, m_held_before;
  bit          all_diff;
  int          edge_n;
  bit          rep_on;
  bit [NK-1:0] rep_owner;
  int          rep_next;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_rel  = '1;
      rep_on = 1'b0;
      edge_n = 0;
      for (int k = 0; k < NK; k++)
        for (int j = 0; j <= DB; j++) hist[k][j] = 1'b1;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      edge_n++;
      m_held_before = ~m_rel;
      m_new   = m_rel;
      m_press = '0;
      for (int k = 0; k < NK; k++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DB; j++) if (hist[k][j] == m_rel[k]) all_diff = 1'b0;
        if (all_diff) begin
          m_new[k] = ~m_rel[k];
          if (m_rel[k]) m_press[k] = 1'b1;
        end
        for (int j = DB; j >= 1; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = key[k];
      end
      m_pulse = '0;
      if (m_held_before == '0) begin
        for (int k = NK - 1; k >= 0; k--) if (m_press[k]) m_pulse = NK'(1) << k;
      end
`ifdef KEY_AUTOREPEAT_EN
      if (m_pulse != '0) begin
        rep_on    = 1'b1;
        rep_owner = m_pulse;
        rep_next  = edge_n + RD;
      end else if (rep_on) begin
        if (((~m_new & rep_owner) == '0) || ((~m_new & ~rep_owner) != '0)) rep_on = 1'b0;
        else if (edge_n == rep_next) begin
          m_pulse  = rep_owner;
          rep_next = rep_next + RP;
        end
      end
`endif
      m_rel = m_new;
      exp_q.push_back('{pulse: m_pulse, held: ~m_new, any: (m_new != '1)});
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_posedge_key", posedge_key, e.pulse);
      chk("sb_key_held", key_held, e.held);
      chk("sb_any_held", any_held, e.any);
      chk("sb_onehot", $onehot0(posedge_key), 1);
      for (int i = 0; i < NK; i++) pulse_cnt[i] += posedge_key[i];
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  int base;

  initial begin
    for (int i = 0; i < NK; i++) pulse_cnt[i] = 0;
    step(3);
    chk("reset_pulse", posedge_key, 0);
    chk("reset_held", {any_held, key_held}, 0);
    @(posedge clock); #3 reset = 1'b1;
    step(8);

    // 1: clean press of key 0, pulse after edge 6, release without pulse
    key[0] = 1'b0;
    step(5); chk("t1_no_early", posedge_key, 0);
    step(1); chk("t1_pulse", posedge_key, 4'b0001);
    step(1); chk("t1_pulse_gone", posedge_key, 0);
    chk("t1_held", {any_held, key_held}, 5'b10001);
    step(4);
    key[0] = 1'b1;
    step(5); chk("t1_still_held", key_held, 4'b0001);
    step(1); chk("t1_released", {any_held, key_held}, 0);
    step(4); chk("t1_one_pulse", pulse_cnt[0], 1);

    // 2: bouncy press on key 1
    key[1] = 1'b0; step(3);
    key[1] = 1'b1; step(1);
    key[1] = 1'b0;
    step(5); chk("t2_no_bounce_pulse", pulse_cnt[1], 0);
    step(1); chk("t2_pulse", posedge_key, 4'b0010);
    step(4);
    key[1] = 1'b1; step(10);
    chk("t2_one_pulse", pulse_cnt[1], 1);

    // 3: simultaneous press, lowest wins; suppressed key needs a fresh press
    key[3:2] = 2'b00;
    step(6); chk("t3_low_wins", posedge_key, 4'b0100);
    step(4);
    key[2] = 1'b1; step(10);
    chk("t3_suppressed", pulse_cnt[3], 0);
    chk("t3_k3_held", key_held, 4'b1000);
    key[3] = 1'b1; step(10);
    key[3] = 1'b0;
    step(6); chk("t3_repress", posedge_key, 4'b1000);
    step(4);
    key[3] = 1'b1; step(10);

    // 4: reset mid-hold, asynchronous clear, held key re-presses after release
    key[0] = 1'b0; step(10);
    chk("t4_held_before", key_held, 4'b0001);
    @(posedge clock); #2 reset = 1'b0;
    #1 chk("t4_async_clear", {posedge_key, key_held, any_held}, 0);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    repeat (5) @(posedge clock);
    #1 chk("t4_no_early", posedge_key, 0);
    @(posedge clock);
    #1 chk("t4_pulse_after_reset", posedge_key, 4'b0001);
    step(4);
    key[0] = 1'b1; step(10);

    // 5: glitch of DB-1 cycles on key 3
    base = pulse_cnt[3];
    key[3] = 1'b0; step(DB - 1);
    key[3] = 1'b1; step(12);
    chk("t5_no_pulse", pulse_cnt[3] - base, 0);
    chk("t5_no_held", key_held, 0);

`ifdef KEY_AUTOREPEAT_EN
    // 6: auto-repeat on key 1
    key[1] = 1'b0;
    step(6); chk("t6_initial", posedge_key, 4'b0010);
    step(RD); chk("t6_first_repeat", posedge_key, 4'b0010);
    step(RP); chk("t6_second_repeat", posedge_key, 4'b0010);
    step(30);
    key[1] = 1'b1; step(8);
    base = pulse_cnt[1];
    step(30); chk("t6_stopped", pulse_cnt[1] - base, 0);
`endif

    // random traffic: short flips act as glitches, long ones as real presses/releases
    repeat (400) begin
      if ($urandom_range(0, 3) != 0) key[$urandom_range(0, NK - 1)] ^= 1'b1;
      step($urandom_range(1, 12));
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clock); #2 reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #3 reset = 1'b1;
      end
    end
    key = '1; step(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
